// File: rtl/regfile_sb_pkg.sv
// Shared types and defaults for the scoreboarded register file.
// Default geometry is 32 x 32-bit; register 0 reads as zero.
package regfile_sb_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_AW    = 5;

    typedef logic [DEF_AW-1:0]    regaddr_t;
    typedef logic [DEF_WIDTH-1:0] word_t;

    localparam regaddr_t REG_ZERO = '0;

    // Register 0 never holds state, so it is never busy.
    function automatic logic is_real_reg(input regaddr_t addr);
        return addr != REG_ZERO;
    endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// Decode/writeback bus of the register file: two read ports, writeback, issue, stall.
// The master is the core pipeline, the slave is the register file.
interface regfile_sb_if #(
    parameter int WIDTH = 32,
    parameter int AW    = 5
);
    logic             i_re_a;
    logic [AW-1:0]    i_raddr_a;
    logic [WIDTH-1:0] o_rdata_a;
    logic             o_rvalid_a;
    logic             o_hazard_a;

    logic             i_re_b;
    logic [AW-1:0]    i_raddr_b;
    logic [WIDTH-1:0] o_rdata_b;
    logic             o_rvalid_b;
    logic             o_hazard_b;

    logic             i_we;
    logic [AW-1:0]    i_waddr;
    logic [WIDTH-1:0] i_wdata;

    logic             i_issue;
    logic [AW-1:0]    i_issue_addr;

    logic             o_stall;

    modport master (
        output i_re_a, i_raddr_a, i_re_b, i_raddr_b,
        output i_we, i_waddr, i_wdata, i_issue, i_issue_addr,
        input  o_rdata_a, o_rvalid_a, o_hazard_a,
        input  o_rdata_b, o_rvalid_b, o_hazard_b, o_stall
    );

    modport slave (
        input  i_re_a, i_raddr_a, i_re_b, i_raddr_b,
        input  i_we, i_waddr, i_wdata, i_issue, i_issue_addr,
        output o_rdata_a, o_rvalid_a, o_hazard_a,
        output o_rdata_b, o_rvalid_b, o_hazard_b, o_stall
    );
endinterface

// File: rtl/regfile_sb_port.sv
// One read port: hazard detection, write-first bypass and the output register.
// rdata holds its last value when no read is accepted; rvalid is a one-cycle pulse.
module regfile_sb_port #(
    parameter int WIDTH = 32,
    parameter int AW    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             busy_hit,
    input  logic [WIDTH-1:0] stored,
    output logic [WIDTH-1:0] rdata,
    output logic             rvalid,
    output logic             hazard
);

    logic             is_zero;
    logic             write_hit;
    logic             accept;
    logic [WIDTH-1:0] next_data;

    assign is_zero   = (raddr == '0);
    // A writeback to the same register this cycle satisfies the pending producer.
    assign write_hit = we && (waddr == raddr) && !is_zero;
    assign hazard    = busy_hit && !write_hit && !is_zero;
    assign accept    = re && !hazard;

    always_comb begin
        next_data = stored;
        if (is_zero) begin
            next_data = '0;
        end else if (write_hit) begin
            next_data = wdata;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rvalid <= 1'b0;
            rdata  <= '0;
        end else begin
            rvalid <= accept;
            if (accept) begin
                rdata <= next_data;
            end
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Two-read/one-write register file with a per-register pending-write scoreboard.
// Storage and the busy vector live here; each read port is a regfile_sb_port.
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter int               WIDTH = DEF_WIDTH,
    parameter int               AW    = DEF_AW,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic        i_clk,
    input  logic        i_rst,
    regfile_sb_if.slave bus
);

    localparam int NREG = 1 << AW;

    logic [WIDTH-1:0] regs [NREG-1:1];
    logic [NREG-1:0]  busy;
    logic [NREG-1:0]  busy_next;

    logic             wr_real;
    logic             issue_real;
    logic [WIDTH-1:0] stored_a;
    logic [WIDTH-1:0] stored_b;

    assign wr_real    = bus.i_we && (bus.i_waddr != '0);
    assign issue_real = bus.i_issue && (bus.i_issue_addr != '0);

    // NOTE: the storage array is reset on purpose -- every register must read INIT after reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            for (int i = 1; i < NREG; i++) begin
                regs[i] <= INIT;
            end
        end else if (wr_real) begin
            regs[bus.i_waddr] <= bus.i_wdata;
        end
    end

    // NOTE: a default assignment first keeps every always_comb path defined, so no latch is inferred.
    always_comb begin
        busy_next = busy;
        if (wr_real) begin
            busy_next[bus.i_waddr] = 1'b0;
        end
        // Issue applied after writeback: a new producer wins over a retiring one.
        if (issue_real) begin
            busy_next[bus.i_issue_addr] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    always_comb begin
        stored_a = '0;
        stored_b = '0;
        if (bus.i_raddr_a != '0) begin
            stored_a = regs[bus.i_raddr_a];
        end
        if (bus.i_raddr_b != '0) begin
            stored_b = regs[bus.i_raddr_b];
        end
    end

    regfile_sb_port #(.WIDTH(WIDTH), .AW(AW)) u_port_a (
        .clk      (i_clk),
        .rst      (i_rst),
        .re       (bus.i_re_a),
        .raddr    (bus.i_raddr_a),
        .we       (bus.i_we),
        .waddr    (bus.i_waddr),
        .wdata    (bus.i_wdata),
        .busy_hit (busy[bus.i_raddr_a]),
        .stored   (stored_a),
        .rdata    (bus.o_rdata_a),
        .rvalid   (bus.o_rvalid_a),
        .hazard   (bus.o_hazard_a)
    );

    regfile_sb_port #(.WIDTH(WIDTH), .AW(AW)) u_port_b (
        .clk      (i_clk),
        .rst      (i_rst),
        .re       (bus.i_re_b),
        .raddr    (bus.i_raddr_b),
        .we       (bus.i_we),
        .waddr    (bus.i_waddr),
        .wdata    (bus.i_wdata),
        .busy_hit (busy[bus.i_raddr_b]),
        .stored   (stored_b),
        .rdata    (bus.o_rdata_b),
        .rvalid   (bus.o_rvalid_b),
        .hazard   (bus.o_hazard_b)
    );

    assign bus.o_stall = (bus.o_hazard_a && bus.i_re_a) || (bus.o_hazard_b && bus.i_re_b);

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: array-based reference model checked every cycle,
// plus directed vectors with literal expectations.
module tb_regfile_sb;
    import regfile_sb_pkg::*;

    localparam word_t INIT = 32'hC0DE_0001;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    regfile_sb_if #(.WIDTH(32), .AW(5)) bus ();

    regfile_sb #(.WIDTH(32), .AW(5), .INIT(INIT)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: architectural state plus expected registered outputs.
    word_t model_regs [32];
    bit    model_busy [32];
    bit    live = 1'b0;
    bit    exp_rvalid_a, exp_rvalid_b;
    word_t exp_rdata_a, exp_rdata_b;

    function automatic bit model_hazard(input regaddr_t ra);
        if (ra == REG_ZERO) return 1'b0;
        if (bus.i_we && bus.i_waddr == ra) return 1'b0;
        return model_busy[ra];
    endfunction

    function automatic word_t model_read(input regaddr_t ra);
        if (ra == REG_ZERO) return '0;
        if (bus.i_we && bus.i_waddr == ra) return bus.i_wdata;
        return model_regs[ra];
    endfunction

    always @(posedge clk) begin
        if (!rst) begin
            live = 1'b1;
            foreach (model_regs[i]) model_regs[i] = INIT;
            foreach (model_busy[i]) model_busy[i] = 1'b0;
            exp_rvalid_a = 1'b0;
            exp_rvalid_b = 1'b0;
            exp_rdata_a  = '0;
            exp_rdata_b  = '0;
        end else begin
            exp_rvalid_a = bus.i_re_a && !model_hazard(bus.i_raddr_a);
            exp_rvalid_b = bus.i_re_b && !model_hazard(bus.i_raddr_b);
            if (exp_rvalid_a) exp_rdata_a = model_read(bus.i_raddr_a);
            if (exp_rvalid_b) exp_rdata_b = model_read(bus.i_raddr_b);
            if (bus.i_we && bus.i_waddr != REG_ZERO) begin
                model_regs[bus.i_waddr] = bus.i_wdata;
                model_busy[bus.i_waddr] = 1'b0;
            end
            if (bus.i_issue && bus.i_issue_addr != REG_ZERO) begin
                model_busy[bus.i_issue_addr] = 1'b1;
            end
        end
    end

    // Mid-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (live) begin
            check("m_hazard_a", 32'(bus.o_hazard_a), 32'(model_hazard(bus.i_raddr_a)));
            check("m_hazard_b", 32'(bus.o_hazard_b), 32'(model_hazard(bus.i_raddr_b)));
            check("m_stall", 32'(bus.o_stall),
                  32'((bus.i_re_a && model_hazard(bus.i_raddr_a)) ||
                      (bus.i_re_b && model_hazard(bus.i_raddr_b))));
            check("m_rvalid_a", 32'(bus.o_rvalid_a), 32'(exp_rvalid_a));
            check("m_rvalid_b", 32'(bus.o_rvalid_b), 32'(exp_rvalid_b));
            check("m_rdata_a", bus.o_rdata_a, exp_rdata_a);
            check("m_rdata_b", bus.o_rdata_b, exp_rdata_b);
        end
    end

    task automatic drive(input logic re_a, input regaddr_t ra, input logic re_b, input regaddr_t rb,
                         input logic we, input regaddr_t wa, input word_t wd,
                         input logic iss, input regaddr_t ia);
        bus.i_re_a = re_a;  bus.i_raddr_a = ra;
        bus.i_re_b = re_b;  bus.i_raddr_b = rb;
        bus.i_we = we;      bus.i_waddr = wa;     bus.i_wdata = wd;
        bus.i_issue = iss;  bus.i_issue_addr = ia;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, '0, 0, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    initial begin
        idle();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;

        // Reset value visible through a read of x5.
        drive(1, 5, 0, 0, 0, 0, '0, 0, 0);
        mid(); check("rst_stall", 32'(bus.o_stall), 32'd0);
        tick(); idle();
        mid(); check("rst_rdata", bus.o_rdata_a, INIT);
        check("rst_rvalid", 32'(bus.o_rvalid_a), 32'd1);
        tick();
        mid(); check("rvalid_pulse", 32'(bus.o_rvalid_a), 32'd0);
        tick();

        // Write then read on both ports.
        drive(0, 0, 0, 0, 1, 3, 32'hDEADBEEF, 0, 0);
        tick();
        drive(1, 3, 1, 3, 0, 0, '0, 0, 0);
        tick(); idle();
        mid(); check("wr_rd_a", bus.o_rdata_a, 32'hDEADBEEF);
        check("wr_rd_b", bus.o_rdata_b, 32'hDEADBEEF);
        tick();

        // Same-cycle write/read bypass.
        drive(1, 7, 0, 0, 1, 7, 32'h12345678, 0, 0);
        tick(); idle();
        mid(); check("bypass", bus.o_rdata_a, 32'h12345678);
        tick();

        // Register zero ignores writes and issues.
        drive(1, 0, 1, 0, 1, 0, 32'hFFFFFFFF, 1, 0);
        mid(); check("x0_hazard", 32'(bus.o_hazard_a), 32'd0);
        tick(); idle();
        mid(); check("x0_rdata_a", bus.o_rdata_a, 32'd0);
        check("x0_rdata_b", bus.o_rdata_b, 32'd0);
        check("x0_rvalid", 32'(bus.o_rvalid_a), 32'd1);
        tick();

        // Scoreboard hazard, retry, and resolution by writeback.
        drive(0, 0, 0, 0, 0, 0, '0, 1, 9);
        tick();
        drive(1, 9, 0, 0, 0, 0, '0, 0, 0);
        mid(); check("sb_hazard", 32'(bus.o_hazard_a), 32'd1);
        check("sb_stall", 32'(bus.o_stall), 32'd1);
        tick();
        mid(); check("sb_rejected", 32'(bus.o_rvalid_a), 32'd0);
        check("sb_hold", bus.o_rdata_a, 32'd0);
        tick();
        drive(1, 9, 0, 0, 1, 9, 32'h000000A5, 0, 0);
        mid(); check("sb_resolved", 32'(bus.o_hazard_a), 32'd0);
        tick(); idle();
        mid(); check("sb_data", bus.o_rdata_a, 32'h000000A5);
        tick();

        // Issue and writeback to the same register: still pending.
        drive(0, 0, 0, 0, 1, 9, 32'h77, 1, 9);
        tick();
        drive(0, 0, 1, 9, 0, 0, '0, 0, 0);
        mid(); check("set_wins", 32'(bus.o_hazard_b), 32'd1);
        tick();
        drive(0, 0, 1, 9, 1, 9, 32'h88, 0, 0);
        tick(); idle();
        mid(); check("set_wins_data", bus.o_rdata_b, 32'h88);
        tick();

        // Back-to-back reads with interleaved writes.
        drive(1, 3, 1, 7, 1, 3, 32'h0000_1111, 0, 0);
        tick();
        drive(1, 7, 1, 3, 1, 12, 32'h0000_2222, 1, 13);
        tick();
        drive(1, 12, 1, 13, 0, 0, '0, 0, 0);
        tick();
        drive(1, 3, 1, 13, 1, 13, 32'h0000_3333, 0, 0);
        tick(); idle();
        mid(); check("b2b_a", bus.o_rdata_a, 32'h0000_1111);
        check("b2b_b", bus.o_rdata_b, 32'h0000_3333);
        tick();

        // Reset in the middle of a read drops it and clears the scoreboard.
        drive(0, 0, 1, 2, 0, 0, '0, 1, 4);
        tick();
        drive(1, 2, 0, 0, 1, 2, 32'h5555, 1, 6);
        rst = 1'b0;
        tick();
        rst = 1'b1; idle();
        mid(); check("rst_drop", 32'(bus.o_rvalid_a), 32'd0);
        drive(1, 4, 1, 2, 0, 0, '0, 0, 0);
        mid(); check("rst_busy_clr", 32'(bus.o_hazard_a), 32'd0);
        tick(); idle();
        mid(); check("rst_x2_init", bus.o_rdata_b, INIT);
        check("rst_x4_valid", 32'(bus.o_rvalid_a), 32'd1);
        tick();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
